// File: rtl/fp_add_issue_unit.sv
// FP add/sub issue unit: in-order request queue feeding a combinational adder,
// one registered tagged result at a time over valid/ready, with sticky fflags.
module fpadder #(
    parameter int EXPONENT_WIDTH                = 8,
    parameter int MANTISSA_WIDTH                = 23,
    parameter bit ROUND_TO_NEAREST_TIES_TO_EVEN = 1,
    parameter bit IGNORE_SIGN_BIT_FOR_NAN       = 1
) (
    input  logic                                  valid_in,
    input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] a_in,
    input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] b_in,
    input  logic                                  sub_in,
    output logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] result_out,
    output logic [2:0]                            flags_out
);
    localparam int E  = EXPONENT_WIDTH;
    localparam int M  = MANTISSA_WIDTH;
    localparam int SW = M + 4;   // hidden + mantissa + guard/round/sticky
    localparam int EW = E + 2;
    localparam int MW = M + 2;

    logic          sa, sb, sx, sy, swap, stk, inexact, rup, ovf, is_zero, rsign;
    logic          nan_a, nan_b, inf_a, inf_b;
    logic [E-1:0]  ea, eb;
    logic [M-1:0]  fa, fb;
    logic [M:0]    mx, my;
    logic [EW-1:0] exa, exb, ex, ey, dsh, e;
    logic [SW-1:0] xal, yext, yal, mask, nrm;
    logic [SW:0]   sum;
    logic [MW-1:0] mr;

    always_comb begin
        sa    = a_in[E+M];
        ea    = a_in[E+M-1:M];
        fa    = a_in[M-1:0];
        sb    = b_in[E+M] ^ sub_in;
        eb    = b_in[E+M-1:M];
        fb    = b_in[M-1:0];
        nan_a = (&ea) & (|fa);
        nan_b = (&eb) & (|fb);
        inf_a = (&ea) & ~(|fa);
        inf_b = (&eb) & ~(|fb);
        // Larger magnitude goes to x so subtraction never goes negative
        swap  = {eb, fb} > {ea, fa};
        sx    = swap ? sb : sa;
        sy    = swap ? sa : sb;
        mx    = swap ? {|eb, fb} : {|ea, fa};
        my    = swap ? {|ea, fa} : {|eb, fb};
        exa   = (ea == '0) ? EW'(1) : EW'(ea);
        exb   = (eb == '0) ? EW'(1) : EW'(eb);
        ex    = swap ? exb : exa;
        ey    = swap ? exa : exb;
        dsh   = ex - ey;
        yext  = {my, 3'b000};
        mask  = '0;
        if (dsh >= EW'(SW)) begin
            yal = '0;
            stk = |my;
        end else begin
            mask = (SW'(1) << dsh) - SW'(1);
            yal  = yext >> dsh;
            stk  = |(yext & mask);
        end
        yal[0] = yal[0] | stk;
        xal    = {mx, 3'b000};
        sum    = (sx == sy) ? ({1'b0, xal} + {1'b0, yal}) : ({1'b0, xal} - {1'b0, yal});
        e      = ex;
        if (sum[SW]) begin
            nrm = {sum[SW:2], |sum[1:0]};
            e   = e + EW'(1);
        end else begin
            nrm = sum[SW-1:0];
            // Normalise left, stopping at the minimum exponent (subnormal result)
            for (int i = 0; i < SW; i++) begin
                if (!nrm[SW-1] && (e > EW'(1))) begin
                    nrm = nrm << 1;
                    e   = e - EW'(1);
                end
            end
        end
        inexact = |nrm[2:0];
        rup     = ROUND_TO_NEAREST_TIES_TO_EVEN & nrm[2] & (nrm[1] | nrm[0] | nrm[3]);
        mr      = {1'b0, nrm[SW-1:3]} + MW'(rup);
        if (mr[M+1]) begin
            mr = mr >> 1;
            e  = e + EW'(1);
        end
        is_zero = ~(|mr);
        ovf     = mr[M] & (e >= EW'({E{1'b1}}));
        // Exact cancellation yields +0 unless both addends are -0
        rsign   = is_zero ? (sa & sb) : sx;

        result_out = {rsign, (mr[M] ? e[E-1:0] : {E{1'b0}}), mr[M-1:0]};
        flags_out  = {2'b00, ~mr[M] & inexact};
        if (ovf) begin
            result_out = ROUND_TO_NEAREST_TIES_TO_EVEN ? {sx, {E{1'b1}}, {M{1'b0}}}
                                                       : {sx, {(E-1){1'b1}}, 1'b0, {M{1'b1}}};
            flags_out  = 3'b010;
        end
        if (nan_a | nan_b | (inf_a & inf_b & (sa ^ sb))) begin
            result_out = {IGNORE_SIGN_BIT_FOR_NAN, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};
            flags_out  = 3'b100;
        end else if (inf_a | inf_b) begin
            result_out = {sx, {E{1'b1}}, {M{1'b0}}};
            flags_out  = 3'b000;
        end
        if (!valid_in) begin
            result_out = '0;
            flags_out  = '0;
        end
    end
endmodule

module fp_add_issue_unit #(
    parameter int EXPONENT_WIDTH = 8,
    parameter int MANTISSA_WIDTH = 23,
    parameter int TAG_WIDTH      = 4,
    parameter int QUEUE_DEPTH    = 4
) (
    input  logic                                  clk_in,
    input  logic                                  rst_N_in,
    input  logic                                  req_valid_in,
    output logic                                  req_ready_out,
    input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] req_a_in,
    input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] req_b_in,
    input  logic                                  req_sub_in,
    input  logic [TAG_WIDTH-1:0]                  req_tag_in,
    output logic                                  resp_valid_out,
    input  logic                                  resp_ready_in,
    output logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] resp_result_out,
    output logic [TAG_WIDTH-1:0]                  resp_tag_out,
    output logic [2:0]                            resp_flags_out,
    output logic [2:0]                            fflags_out,
    input  logic                                  fflags_clear_in,
    output logic [$clog2(QUEUE_DEPTH):0]          count_out
);
    localparam int FW = EXPONENT_WIDTH + MANTISSA_WIDTH + 1;
    localparam int PW = $clog2(QUEUE_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {IDLE, HOLD} state_t;

    logic [FW-1:0]        q_a   [QUEUE_DEPTH];
    logic [FW-1:0]        q_b   [QUEUE_DEPTH];
    logic                 q_sub [QUEUE_DEPTH];
    logic [TAG_WIDTH-1:0] q_tag [QUEUE_DEPTH];
    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic [CW-1:0]        count;
    logic                 empty, push, pop, hs;
    state_t               state, state_nx;
    logic [FW-1:0]        add_a, add_b, add_res;
    logic                 add_sub;
    logic [2:0]           add_flags;

    assign empty          = (count == '0);
    assign req_ready_out  = (count < CW'(QUEUE_DEPTH));
    assign push           = req_valid_in & req_ready_out;
    assign resp_valid_out = (state == HOLD);
    assign hs             = resp_valid_out & resp_ready_in;
    assign count_out      = count;
    assign add_a          = empty ? '0 : q_a[rd_ptr];
    assign add_b          = empty ? '0 : q_b[rd_ptr];
    assign add_sub        = empty ? 1'b0 : q_sub[rd_ptr];

    fpadder #(
        .EXPONENT_WIDTH               (EXPONENT_WIDTH),
        .MANTISSA_WIDTH               (MANTISSA_WIDTH),
        .ROUND_TO_NEAREST_TIES_TO_EVEN(1'b1),
        .IGNORE_SIGN_BIT_FOR_NAN      (1'b1)
    ) u_fpadder (
        .valid_in  (~empty),
        .a_in      (add_a),
        .b_in      (add_b),
        .sub_in    (add_sub),
        .result_out(add_res),
        .flags_out (add_flags)
    );

    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        case (state)
            IDLE: if (!empty) begin
                pop      = 1'b1;
                state_nx = HOLD;
            end
            HOLD: if (resp_ready_in) begin
                if (!empty) pop = 1'b1;
                else        state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Storage needs no reset: count gates every read
    always_ff @(posedge clk_in) begin
        if (push) begin
            q_a[wr_ptr]   <= req_a_in;
            q_b[wr_ptr]   <= req_b_in;
            q_sub[wr_ptr] <= req_sub_in;
            q_tag[wr_ptr] <= req_tag_in;
        end
    end

    always_ff @(posedge clk_in or negedge rst_N_in) begin
        if (!rst_N_in) begin
            state           <= IDLE;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            count           <= '0;
            resp_result_out <= '0;
            resp_tag_out    <= '0;
            resp_flags_out  <= '0;
            fflags_out      <= '0;
        end else begin
            state <= state_nx;
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (pop) begin
                resp_result_out <= add_res;
                resp_tag_out    <= q_tag[rd_ptr];
                resp_flags_out  <= add_flags;
            end
            // Flags of a handshake landing with a clear still get recorded
            fflags_out <= (fflags_clear_in ? 3'b000 : fflags_out) | (hs ? resp_flags_out : 3'b000);
        end
    end
endmodule

// File: tb/tb_fp_add_issue_unit.sv
// Bench for fp_add_issue_unit: real-arithmetic FP32 reference with a response
// scoreboard checked every cycle, plus directed literal checks.
module tb_fp_add_issue_unit;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] r;
        logic [3:0]  tag;
        logic [2:0]  fl;
    } resp_t;

    logic        clk_in = 1'b0;
    logic        rst_N_in;
    logic        req_valid_in, req_ready_out, req_sub_in;
    logic [31:0] req_a_in, req_b_in;
    logic [3:0]  req_tag_in;
    logic        resp_valid_out, resp_ready_in;
    logic [31:0] resp_result_out;
    logic [3:0]  resp_tag_out;
    logic [2:0]  resp_flags_out, fflags_out;
    logic        fflags_clear_in;
    logic [2:0]  count_out;

    int checks = 0;
    int failures = 0;

    resp_t exp_q[$];
    resp_t m_hold;
    logic  m_held = 1'b0;
    logic  m_hs, m_push;
    logic [2:0] m_ff = 3'b000;

    fp_add_issue_unit dut (
        .clk_in(clk_in), .rst_N_in(rst_N_in),
        .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
        .req_a_in(req_a_in), .req_b_in(req_b_in), .req_sub_in(req_sub_in), .req_tag_in(req_tag_in),
        .resp_valid_out(resp_valid_out), .resp_ready_in(resp_ready_in),
        .resp_result_out(resp_result_out), .resp_tag_out(resp_tag_out), .resp_flags_out(resp_flags_out),
        .fflags_out(fflags_out), .fflags_clear_in(fflags_clear_in), .count_out(count_out)
    );

    always #5 clk_in = ~clk_in;

    initial begin
        #400000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic real f2r(input logic [31:0] f);
        if (f[30:23] == 8'h00) return $bitstoreal({f[31], 63'b0});
        return $bitstoreal({f[31], 11'(int'(f[30:23]) - 127 + 1023), f[22:0], 29'b0});
    endfunction

    // Round an exact double to FP32, nearest-even
    task automatic to_f32(input real s, output logic [31:0] r, output logic [2:0] fl);
        logic [63:0] d;
        logic [24:0] k;
        logic [28:0] rest;
        int e;
        d  = $realtobits(s);
        fl = 3'b000;
        if (d[62:0] == 63'b0) begin
            r = {d[63], 31'b0};
        end else begin
            e    = int'(d[62:52]) - 1023 + 127;
            k    = {2'b01, d[51:29]};
            rest = d[28:0];
            if (rest > 29'h1000_0000 || (rest == 29'h1000_0000 && k[0])) k = k + 25'd1;
            if (k[24]) begin
                k = k >> 1;
                e++;
            end
            if (e >= 255) begin
                r  = {d[63], 8'hFF, 23'b0};
                fl = 3'b010;
            end else begin
                r = {d[63], 8'(e), k[22:0]};
            end
        end
    endtask

    function automatic logic is_nan(input logic [31:0] f);
        return (f[30:23] == 8'hFF) && (f[22:0] != 0);
    endfunction
    function automatic logic is_inf(input logic [31:0] f);
        return (f[30:23] == 8'hFF) && (f[22:0] == 0);
    endfunction

    task automatic model(input logic [31:0] a, input logic [31:0] b, input logic sub,
                         input logic [3:0] tag, output resp_t o);
        logic [31:0] bb;
        bb    = b ^ {sub, 31'b0};
        o.tag = tag;
        o.fl  = 3'b000;
        if (is_nan(a) || is_nan(bb) || (is_inf(a) && is_inf(bb) && a[31] != bb[31])) begin
            o.r  = 32'hFFC00000;
            o.fl = 3'b100;
        end else if (is_inf(a)) begin
            o.r = a;
        end else if (is_inf(bb)) begin
            o.r = bb;
        end else begin
            to_f32(f2r(a) + f2r(bb), o.r, o.fl);
        end
    endtask

    // Reference: queued requests, one held result, sticky flags
    always @(posedge clk_in) begin
        resp_t nr;
        if (!rst_N_in) begin
            exp_q.delete();
            m_held = 1'b0;
            m_ff   = 3'b000;
        end else begin
            m_push = req_valid_in && (exp_q.size() < DEPTH);
            m_hs   = m_held && resp_ready_in;
            m_ff   = (fflags_clear_in ? 3'b000 : m_ff) | (m_hs ? m_hold.fl : 3'b000);
            if (!m_held || m_hs) begin
                if (exp_q.size() > 0) begin
                    m_hold = exp_q.pop_front();
                    m_held = 1'b1;
                end else begin
                    m_held = 1'b0;
                end
            end
            if (m_push) begin
                model(req_a_in, req_b_in, req_sub_in, req_tag_in, nr);
                exp_q.push_back(nr);
            end
        end
    end

    always @(negedge clk_in) begin
        if (rst_N_in) begin
            chk("m_resp_valid", resp_valid_out, m_held);
            if (m_held) begin
                chk("m_result", resp_result_out, m_hold.r);
                chk("m_tag", resp_tag_out, m_hold.tag);
                chk("m_flags", resp_flags_out, m_hold.fl);
            end
            chk("m_count", count_out, exp_q.size());
            chk("m_req_ready", req_ready_out, exp_q.size() < DEPTH);
            chk("m_fflags", fflags_out, m_ff);
        end
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic sub, input logic [3:0] tag);
        logic acc;
        acc          = 1'b0;
        req_valid_in = 1'b1;
        req_a_in     = a;
        req_b_in     = b;
        req_sub_in   = sub;
        req_tag_in   = tag;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk_in);
            acc = req_ready_out;
            step();
        end
        if (!acc) begin
            failures++;
            $display("FAIL send_timeout tag=%0d actual=not_accepted expected=accepted", tag);
        end
        req_valid_in = 1'b0;
    endtask

    logic [31:0] sp_a[6] = '{32'h7FC00000, 32'h7F800000, 32'h7F7FFFFF, 32'h3F800000, 32'h7F800000, 32'h00000000};
    logic [31:0] sp_b[6] = '{32'h3F800000, 32'hFF800000, 32'h7F7FFFFF, 32'h3F800000, 32'h40000000, 32'h80000000};
    logic        sp_s[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        int ea, eb, k;
        rst_N_in = 1'b0;
        req_valid_in = 1'b0; req_a_in = '0; req_b_in = '0; req_sub_in = 1'b0; req_tag_in = '0;
        resp_ready_in = 1'b1; fflags_clear_in = 1'b0;
        #1;
        chk("rst_resp_valid", resp_valid_out, 0);
        chk("rst_count", count_out, 0);
        chk("rst_req_ready", req_ready_out, 1);
        chk("rst_result", resp_result_out, 0);
        chk("rst_tag", resp_tag_out, 0);
        chk("rst_flags", resp_flags_out, 0);
        chk("rst_fflags", fflags_out, 0);
        repeat (3) step();
        rst_N_in = 1'b1;
        step();

        // 1.0 + 2.0 into an idle unit
        send(32'h3F800000, 32'h40000000, 1'b0, 4'd3);
        chk("t1_not_yet_valid", resp_valid_out, 0);
        step();
        chk("t1_valid", resp_valid_out, 1);
        chk("t1_result", resp_result_out, 32'h40400000);
        chk("t1_tag", resp_tag_out, 3);
        chk("t1_flags", resp_flags_out, 0);

        send(32'h3F800000, 32'h3F800000, 1'b1, 4'd7);
        step();
        chk("t2_sub_result", resp_result_out, 32'h00000000);
        chk("t2_sub_tag", resp_tag_out, 7);
        chk("t2_sub_flags", resp_flags_out, 0);
        send(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 4'd8);
        step();
        chk("t2_ovf_result", resp_result_out, 32'h7F800000);
        chk("t2_ovf_flags", resp_flags_out, 3'b010);
        step();
        chk("t2_fflags", fflags_out, 3'b010);

        fflags_clear_in = 1'b1; step(); fflags_clear_in = 1'b0;
        chk("t4_cleared", fflags_out, 0);
        send(32'h7FC00000, 32'h3F800000, 1'b0, 4'd1);
        step();
        chk("t4_nan_result", resp_result_out, 32'hFFC00000);
        chk("t4_nan_flags", resp_flags_out, 3'b100);
        step();
        chk("t4_fflags_set", fflags_out, 3'b100);
        send(32'h3F800000, 32'h3F800000, 1'b0, 4'd2);
        step(); step();
        chk("t4_fflags_sticky", fflags_out, 3'b100);
        fflags_clear_in = 1'b1; step(); fflags_clear_in = 1'b0;
        chk("t4_fflags_clear", fflags_out, 0);
        resp_ready_in = 1'b0;
        send(32'h7FC00000, 32'h3F800000, 1'b0, 4'd4);
        step();
        fflags_clear_in = 1'b1; resp_ready_in = 1'b1;
        step();
        fflags_clear_in = 1'b0;
        chk("t4_clear_vs_hs", fflags_out, 3'b100);

        send(32'h7F800000, 32'hFF800000, 1'b0, 4'd5);
        step();
        chk("t5_inf_minus_inf", resp_result_out, 32'hFFC00000);
        chk("t5_inf_flags", resp_flags_out, 3'b100);
        send(32'h7F800000, 32'h7F800000, 1'b1, 4'd6);
        step();
        chk("t5_inf_sub_inf", resp_result_out, 32'hFFC00000);
        chk("t5_inf_sub_flags", resp_flags_out, 3'b100);
        step();

        // Backpressure: fill queue plus response register
        resp_ready_in = 1'b0;
        for (int t = 0; t < 5; t++) send(32'h3F800000, 32'h40000000, 1'b0, 4'(t));
        req_valid_in = 1'b1; req_tag_in = 4'd5;
        step(); step();
        @(negedge clk_in);
        chk("t3_req_ready", req_ready_out, 0);
        chk("t3_count", count_out, 4);
        chk("t3_held_tag", resp_tag_out, 0);
        chk("t3_held_valid", resp_valid_out, 1);
        step();
        req_valid_in = 1'b0;
        resp_ready_in = 1'b1;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk_in);
            chk("t3_drain_tag", resp_tag_out, t);
        end
        send(32'h3F800000, 32'h40000000, 1'b0, 4'd5);
        step();
        chk("t3_last_tag", resp_tag_out, 5);

        // Random traffic against the reference
        for (int n = 0; n < 500; n++) begin
            req_valid_in = ($urandom % 3) != 0;
            if (($urandom % 8) == 0) begin
                k = $urandom_range(5, 0);
                req_a_in = sp_a[k]; req_b_in = sp_b[k]; req_sub_in = sp_s[k];
            end else begin
                ea = $urandom_range(140, 110);
                eb = ea + $urandom_range(20, 0) - 10;
                req_a_in   = {1'($urandom), 8'(ea), 23'($urandom)};
                req_b_in   = {1'($urandom), 8'(eb), 23'($urandom)};
                req_sub_in = 1'($urandom);
            end
            req_tag_in      = 4'($urandom);
            resp_ready_in   = ($urandom % 4) != 0;
            fflags_clear_in = ($urandom % 20) == 0;
            step();
        end
        req_valid_in = 1'b0; resp_ready_in = 1'b1; fflags_clear_in = 1'b0;
        repeat (10) step();
        chk("rand_drained", exp_q.size() + int'(m_held), 0);

        // Reset in the middle of a backpressured burst
        resp_ready_in = 1'b0;
        for (int t = 0; t < 3; t++) send(32'h40000000, 32'h3F800000, 1'b1, 4'(t + 9));
        #2;
        rst_N_in = 1'b0;
        #1;
        chk("t6_rst_valid", resp_valid_out, 0);
        chk("t6_rst_count", count_out, 0);
        @(posedge clk_in);
        #3;
        rst_N_in = 1'b1;
        resp_ready_in = 1'b1;
        for (int t = 0; t < 5; t++) begin
            step();
            chk("t6_no_stale_valid", resp_valid_out, 0);
            chk("t6_no_stale_count", count_out, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
